// File: rtl/conv_relu_maxpool.sv
// conv_relu_maxpool
// -----------------------------------------------------------------------------
// Sits after the convolution MAC array. Each accepted cycle brings one conv
// output pixel with all FILTERS channels packed side by side. Every channel
// goes through ReLU and then 2x2 / stride-2 max-pooling. Finished pooled pixels
// are written out with their pool coordinates for the next layer's feature-map
// buffer.
//
// Handshake: the input has no ready. A pixel is taken on a clock edge where
// clk_en=1, in_cen=0 and busy=1. Pixels that arrive while busy=0, or in the same
// cycle as start, are dropped. The pixel order is a fixed raster with x fastest.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   clk_en          global enable; every register holds while it is low
//   start           frame start pulse; restarts the frame even while busy
//   in_cen          active-low pixel valid
//   in_data         FILTERS signed lanes, lane k at [k*D_WIDTH +: D_WIDTH]
//   out_data        pooled lanes (always >= 0), same packing as in_data
//   out_x, out_y    pooled column and row of out_data
//   out_we          one-cycle write strobe for out_data/out_x/out_y
//   done            one-cycle pulse after the last pixel of the frame
//   busy            high from start until the frame's last pixel is accepted
// -----------------------------------------------------------------------------
module conv_relu_maxpool #(
    parameter  int I_SIZE  = 32,
    parameter  int F_SIZE  = 5,
    parameter  int STEP    = 1,
    parameter  int FILTERS = 6,
    parameter  int D_WIDTH = 16,
    localparam int O_SIZE  = (I_SIZE - F_SIZE) / STEP + 1,
    localparam int P_SIZE  = O_SIZE / 2,
    localparam int PW      = $clog2(P_SIZE + 1)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clk_en,
    input  logic                       start,
    input  logic                       in_cen,
    input  logic [FILTERS*D_WIDTH-1:0] in_data,
    output logic [FILTERS*D_WIDTH-1:0] out_data,
    output logic [PW-1:0]              out_x,
    output logic [PW-1:0]              out_y,
    output logic                       out_we,
    output logic                       done,
    output logic                       busy
);

    localparam int W  = FILTERS * D_WIDTH;
    localparam int CW = $clog2(O_SIZE + 1);
    localparam int LW = (P_SIZE > 1) ? $clog2(P_SIZE) : 1;

    localparam logic [CW-1:0] X_LAST   = CW'(O_SIZE - 1);
    // Columns/rows at or beyond this limit only exist for odd O_SIZE and are
    // dropped by floor pooling.
    localparam logic [CW-1:0] POOL_LIM = CW'(2 * P_SIZE);

    // Frame position and status
    logic [CW-1:0] x_q, x_d;
    logic [CW-1:0] y_q, y_d;
    logic          busy_q, busy_d;

    // Output registers
    logic [W-1:0]  out_data_q, out_data_d;
    logic [PW-1:0] out_x_q, out_x_d;
    logic [PW-1:0] out_y_q, out_y_d;
    logic          out_we_q, out_we_d;
    logic          done_q, done_d;

    // Pool storage: h_q holds the even-x ReLU value of the current pair.
    // line_buf_q holds the horizontal maxima of the even row for each pool
    // column. Neither is reset, because each entry is written before it is read.
    logic [W-1:0]  h_q;
    logic [W-1:0]  line_buf_q [P_SIZE];

    logic          pix_ok;
    logic          x_odd, y_odd, in_pool;
    logic [LW-1:0] lb_idx;
    logic [W-1:0]  lb_rd;
    logic [W-1:0]  relu_v, hmax_v, pool_v;

    // Qualified by clk_en at the register stage.
    assign pix_ok  = !in_cen && busy_q;
    assign x_odd   = x_q[0];
    assign y_odd   = y_q[0];
    assign in_pool = (x_q < POOL_LIM) && (y_q < POOL_LIM);
    assign lb_idx  = LW'(x_q >> 1);
    assign lb_rd   = line_buf_q[lb_idx];

    // Per-lane ReLU and max compares. After ReLU every value is non-negative,
    // so unsigned compares are exact.
    always_comb begin
        logic [D_WIDTH-1:0] lane, r, hk, hm, lk;
        relu_v = '0;
        hmax_v = '0;
        pool_v = '0;
        lane   = '0;
        r      = '0;
        hk     = '0;
        hm     = '0;
        lk     = '0;
        for (int k = 0; k < FILTERS; k++) begin
            lane = in_data[k*D_WIDTH +: D_WIDTH];
            r    = lane[D_WIDTH-1] ? '0 : lane;
            hk   = h_q[k*D_WIDTH +: D_WIDTH];
            hm   = (hk > r) ? hk : r;
            lk   = lb_rd[k*D_WIDTH +: D_WIDTH];
            relu_v[k*D_WIDTH +: D_WIDTH] = r;
            hmax_v[k*D_WIDTH +: D_WIDTH] = hm;
            pool_v[k*D_WIDTH +: D_WIDTH] = (lk > hm) ? lk : hm;
        end
    end

    // Counters, status and output strobes
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        busy_d     = busy_q;
        out_we_d   = 1'b0;
        done_d     = 1'b0;
        out_data_d = out_data_q;
        out_x_d    = out_x_q;
        out_y_d    = out_y_q;
        if (start) begin
            // start has priority over a pixel in the same cycle.
            x_d    = '0;
            y_d    = '0;
            busy_d = 1'b1;
        end else if (pix_ok) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == X_LAST) begin
                    y_d    = '0;
                    busy_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    y_d = y_q + 1'b1;
                end
            end else begin
                x_d = x_q + 1'b1;
            end
            // The (odd x, odd y) pixel closes a 2x2 window.
            if (in_pool && x_odd && y_odd) begin
                out_we_d   = 1'b1;
                out_data_d = pool_v;
                out_x_d    = PW'(x_q >> 1);
                out_y_d    = PW'(y_q >> 1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q        <= '0;
            y_q        <= '0;
            busy_q     <= 1'b0;
            out_we_q   <= 1'b0;
            done_q     <= 1'b0;
            out_data_q <= '0;
            out_x_q    <= '0;
            out_y_q    <= '0;
        end else if (clk_en) begin
            // Pending out_we/done stay up until the next enabled edge.
            x_q        <= x_d;
            y_q        <= y_d;
            busy_q     <= busy_d;
            out_we_q   <= out_we_d;
            done_q     <= done_d;
            out_data_q <= out_data_d;
            out_x_q    <= out_x_d;
            out_y_q    <= out_y_d;
        end
    end

    always_ff @(posedge clk) begin
        if (clk_en && !start && pix_ok) begin
            if (!x_odd) begin
                h_q <= relu_v;
            end else if (!y_odd && in_pool) begin
                line_buf_q[lb_idx] <= hmax_v;
            end
        end
    end

    assign out_data = out_data_q;
    assign out_x    = out_x_q;
    assign out_y    = out_y_q;
    assign out_we   = out_we_q;
    assign done     = done_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_conv_relu_maxpool.sv
module tb_conv_relu_maxpool;

    localparam int O   = 28;
    localparam int P   = 14;
    localparam int FL  = 6;
    localparam int DW  = 16;
    localparam int W   = FL * DW;
    localparam int PW  = 4;
    localparam int RW  = W + 2 * PW;
    localparam int NPX = O * O;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // main DUT (defaults, O_SIZE=28)
    logic          clk_en = 1'b1;
    logic          start = 1'b0;
    logic          in_cen = 1'b1;
    logic [W-1:0]  in_data = '0;
    logic [W-1:0]  out_data;
    logic [PW-1:0] out_x, out_y;
    logic          out_we, done, busy;

    // odd-size DUT (O_SIZE=5, P_SIZE=2)
    logic          start2 = 1'b0;
    logic          in_cen2 = 1'b1;
    logic [W-1:0]  in_data2 = '0;
    logic [W-1:0]  out_data2;
    logic [1:0]    out_x2, out_y2;
    logic          out_we2, done2, busy2;

    conv_relu_maxpool dut (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start),
        .in_cen(in_cen), .in_data(in_data), .out_data(out_data),
        .out_x(out_x), .out_y(out_y), .out_we(out_we), .done(done), .busy(busy)
    );

    conv_relu_maxpool #(.I_SIZE(9), .F_SIZE(5)) dut2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .start(start2),
        .in_cen(in_cen2), .in_data(in_data2), .out_data(out_data2),
        .out_x(out_x2), .out_y(out_y2), .out_we(out_we2), .done(done2), .busy(busy2)
    );

    // ---------------- bookkeeping ----------------
    int checks = 0;
    int fails  = 0;

    logic [RW-1:0] exp_q[$];
    logic          sb_on = 1'b0;
    int            total_we = 0;
    int            total_done = 0;
    int            mon_fr_we = 0;
    logic          pend_we = 1'b0;
    logic          pend_done = 1'b0;
    logic [RW-1:0] mon_e, mon_a;

    logic signed [DW-1:0] pix_mem [O][O][FL];
    logic [W-1:0]         cap [P][P];

    typedef struct {
        int          mode;
        int          px;
        int          py;
        int          lane;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl[10];

    typedef struct {
        logic [1:0] x;
        logic [1:0] y;
        int         base;
    } vec2_t;
    vec2_t tbl2[4];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- stimulus model ----------------
    task automatic fill_frame(input int mode);
        int v, base, pos, r;
        for (int y = 0; y < O; y++)
            for (int x = 0; x < O; x++)
                for (int k = 0; k < FL; k++) begin
                    base = x + O * y;
                    case (mode)
                        0: v = (k < 5) ? base + 1000 * k : base - 400;
                        1: begin
                            pos = ((x >> 1) + (y >> 1)) % 4;
                            v = (((x & 1) == (pos & 1)) && ((y & 1) == (pos >> 1))) ? 7 : -5;
                        end
                        2: v = -1;
                        default: begin
                            r = $urandom_range(0, 7);
                            v = (r == 0) ? 32'h7FFF : (r == 1) ? 32'h8000 : (r == 2) ? 0 : int'($urandom);
                        end
                    endcase
                    pix_mem[y][x][k] = v[15:0];
                end
    endtask

    // Expected pooled output: max of 0 and the four window pixels, signed.
    task automatic push_expected();
        logic [W-1:0] d;
        int m, sv;
        for (int py = 0; py < P; py++)
            for (int px = 0; px < P; px++) begin
                d = '0;
                for (int k = 0; k < FL; k++) begin
                    m = 0;
                    for (int dy = 0; dy < 2; dy++)
                        for (int dx = 0; dx < 2; dx++) begin
                            sv = pix_mem[2*py+dy][2*px+dx][k];
                            if (sv > m) m = sv;
                        end
                    d[k*DW +: DW] = m[15:0];
                end
                exp_q.push_back({PW'(py), PW'(px), d});
            end
    endtask

    function automatic logic [W-1:0] pack_pix(input int p);
        logic [W-1:0] d;
        d = '0;
        for (int k = 0; k < FL; k++) d[k*DW +: DW] = pix_mem[p / O][p % O][k];
        return d;
    endfunction

    function automatic logic [W-1:0] pack_pix2(input int p);
        logic [W-1:0] d;
        int x, y;
        x = p % 5;
        y = p / 5;
        for (int k = 0; k < FL; k++)
            d[k*DW +: DW] = (x == 4 || y == 4) ? 16'h7FFF : 16'(x + 5 * y + k);
        return d;
    endfunction

    // ---------------- driver ----------------
    task automatic run_frame(input int mode, input int npix, input bit gaps, input bit sb);
        int we0, dn0, n;
        fill_frame(mode);
        for (int i = 0; i < P; i++)
            for (int j = 0; j < P; j++) cap[i][j] = '1;
        if (sb) push_expected();
        sb_on = sb;
        we0 = total_we;
        dn0 = total_done;
        @(posedge clk); #1;
        // pixel presented together with start must be dropped
        clk_en = 1'b1; start = 1'b1; in_cen = 1'b0; in_data = {FL{16'h7FFF}};
        @(posedge clk); #1;
        start = 1'b0;
        for (int p = 0; p < npix; p++) begin
            if (gaps) begin
                n = $urandom_range(0, 2);
                repeat (n) begin
                    if ($urandom_range(0, 1) == 1) begin
                        clk_en = 1'b0; in_cen = 1'($urandom_range(0, 1));
                    end else begin
                        clk_en = 1'b1; in_cen = 1'b1;
                    end
                    in_data = {$urandom, $urandom, $urandom};
                    @(posedge clk); #1;
                end
            end
            clk_en = 1'b1; in_cen = 1'b0; in_data = pack_pix(p);
            @(posedge clk); #1;
        end
        clk_en = 1'b1; in_cen = 1'b1;
        for (int w = 0; w < 40 && (w < 2 || exp_q.size() != 0); w++) begin
            @(posedge clk); #1;
        end
        if (sb) begin
            chk("drain_exp_q_left", exp_q.size(), 0);
            chk("frame_out_we_count", total_we - we0, P * P);
            chk("frame_done_count", total_done - dn0, 1);
            chk("frame_busy_after", busy, 1'b0);
            exp_q.delete();
        end
    endtask

    task automatic tbl_check(input int mode);
        for (int i = 0; i < 10; i++)
            if (tbl[i].mode == mode)
                chk($sformatf("tbl%0d_m%0d_p%0d_%0d_l%0d", i, mode, tbl[i].px, tbl[i].py, tbl[i].lane),
                    cap[tbl[i].py][tbl[i].px][tbl[i].lane*DW +: DW], tbl[i].exp);
    endtask

    task automatic observe2(input int j, inout int n2);
        logic exp_we;
        logic [W-1:0] d;
        exp_we = (j == 7 || j == 9 || j == 17 || j == 19);
        chk($sformatf("odd_out_we_j%0d", j), out_we2, exp_we);
        chk($sformatf("odd_done_j%0d", j), done2, (j == 25));
        if (out_we2 && exp_we && n2 < 4) begin
            d = '0;
            for (int k = 0; k < FL; k++) d[k*DW +: DW] = 16'(tbl2[n2].base + k);
            chk($sformatf("odd_data_n%0d", n2), out_data2, d);
            chk($sformatf("odd_xy_n%0d", n2), {out_y2, out_x2}, {tbl2[n2].y, tbl2[n2].x});
            n2++;
        end
    endtask

    // ---------------- main ----------------
    initial begin
        int we_snap, n2;

        tbl[0] = '{0, 0, 0, 0, 16'd29};
        tbl[1] = '{0, 13, 13, 0, 16'd783};
        tbl[2] = '{0, 5, 2, 0, 16'd151};
        tbl[3] = '{0, 0, 0, 5, 16'd0};
        tbl[4] = '{0, 13, 13, 5, 16'd383};
        tbl[5] = '{0, 13, 13, 2, 16'd2783};
        tbl[6] = '{1, 0, 0, 0, 16'd7};
        tbl[7] = '{1, 7, 9, 3, 16'd7};
        tbl[8] = '{2, 3, 4, 1, 16'd0};
        tbl[9] = '{2, 13, 13, 5, 16'd0};
        tbl2[0] = '{2'd0, 2'd0, 6};
        tbl2[1] = '{2'd1, 2'd0, 8};
        tbl2[2] = '{2'd0, 2'd1, 16};
        tbl2[3] = '{2'd1, 2'd1, 18};

        // scoreboard / monitor, sampled on the falling edge
        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    pend_we = 1'b0;
                    pend_done = 1'b0;
                end else begin
                    if (pend_we) chk("out_we_held_clk_en_low", out_we, 1'b1);
                    if (pend_done) chk("done_held_clk_en_low", done, 1'b1);
                    pend_we = out_we && !clk_en;
                    pend_done = done && !clk_en;
                    if (out_we && clk_en) begin
                        total_we++;
                        mon_fr_we++;
                        cap[out_y][out_x] = out_data;
                        if (sb_on) begin
                            mon_a = {out_y, out_x, out_data};
                            if (exp_q.size() == 0) begin
                                chk("sb_unexpected_out_we", mon_a, '0);
                            end else begin
                                mon_e = exp_q.pop_front();
                                chk("sb_out", mon_a, mon_e);
                            end
                        end
                    end
                    if (done && clk_en) begin
                        total_done++;
                        if (sb_on)
                            chk("done_with_last_we_busy0", {out_we, 8'(mon_fr_we), busy},
                                {1'b1, 8'(P * P), 1'b0});
                    end
                    if (start && clk_en) mon_fr_we = 0;
                end
            end
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_data", out_data, '0);
        chk("rst_out_xy", {out_x, out_y}, '0);
        chk("rst_out_we", out_we, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst2_all", {out_data2, out_x2, out_y2, out_we2, done2, busy2}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // ramp, ReLU patterns
        run_frame(0, NPX, 1'b0, 1'b1);
        tbl_check(0);
        run_frame(1, NPX, 1'b0, 1'b1);
        tbl_check(1);
        run_frame(2, NPX, 1'b0, 1'b1);
        tbl_check(2);

        // bubbles: in_cen gaps and clk_en low cycles
        run_frame(0, NPX, 1'b1, 1'b1);
        tbl_check(0);

        // restart mid-frame after 100 random pixels
        run_frame(3, 100, 1'b0, 1'b0);
        chk("restart_busy_mid", busy, 1'b1);
        run_frame(0, NPX, 1'b0, 1'b1);
        tbl_check(0);

        // asynchronous reset mid-frame
        run_frame(3, 300, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_outputs", {out_data, out_x, out_y, out_we, done, busy}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        // pixels without start are ignored
        we_snap = total_we;
        @(posedge clk); #1;
        for (int p = 0; p < 40; p++) begin
            in_cen = 1'b0;
            in_data = {$urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        in_cen = 1'b1;
        @(posedge clk); #1;
        chk("idle_no_out_we", total_we - we_snap, 0);
        chk("idle_busy", busy, 1'b0);
        run_frame(3, NPX, 1'b0, 1'b1);

        // odd O_SIZE=5: floor pooling, done timing
        n2 = 0;
        @(posedge clk); #1;
        clk_en = 1'b1; start2 = 1'b1; in_cen2 = 1'b0; in_data2 = {FL{16'h7FFF}};
        for (int p = 0; p < 25; p++) begin
            @(posedge clk); #1;
            observe2(p, n2);
            start2 = 1'b0; in_cen2 = 1'b0; in_data2 = pack_pix2(p);
        end
        @(posedge clk); #1;
        observe2(25, n2);
        in_cen2 = 1'b1;
        @(posedge clk); #1;
        observe2(26, n2);
        chk("odd_out_we_total", n2, 4);
        chk("odd_busy_after", busy2, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
